// File: rtl/cpu_boot_sequencer.sv
// rtl/cpu_boot_sequencer.sv - loads instruction memory from a byte stream, then runs top_cpu until halt or timeout
module cpu_boot_sequencer #(
   parameter int          ADDR_W     = 8,
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] HALT_INSTR = 32'h00000073,
   parameter int          MAX_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   len_words,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   input  logic [31:0]       cpu_instr,
   output logic [31:0]       run_cycles,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} state_t;

   state_t           state, state_nxt;
   logic [1:0]       byte_cnt;
   logic [ADDR_W:0]  word_cnt;
   logic [ADDR_W:0]  len_q;
   logic [23:0]      word_buf;
   logic             last_taken;

   logic idle_like, len_ok, start_ok, start_bad;
   logic accept, word_end, last_word, halt_hit, timeout_hit;

   always_comb begin
      idle_like   = (state == IDLE) || (state == HALTED);
      len_ok      = (len_words != '0) && (len_words <= (ADDR_W+1)'(IMEM_DEPTH));
      start_ok    = idle_like && start && len_ok;
      start_bad   = idle_like && start && !len_ok;
      // last_taken drops ready for the write cycle of the final word
      s_ready     = (state == LOAD) && !last_taken;
      accept      = s_valid && s_ready;
      word_end    = accept && (byte_cnt == 2'd3);
      last_word   = (word_cnt == len_q - (ADDR_W+1)'(1));
      halt_hit    = (state == RUN) && (cpu_instr == HALT_INSTR);
      timeout_hit = (state == RUN) && (run_cycles == 32'(MAX_CYCLES - 1));
      busy        = (state == LOAD) || (state == RUN);
      cpu_reset   = (state != RUN);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, HALTED: if (start_ok) state_nxt = LOAD;
         LOAD:         if (last_taken) state_nxt = RUN;
         RUN:          if (halt_hit || timeout_hit) state_nxt = HALTED;
         default:      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_cnt   <= '0;
         word_cnt   <= '0;
         len_q      <= '0;
         word_buf   <= '0;
         last_taken <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         run_cycles <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (start_ok) begin
            byte_cnt   <= '0;
            word_cnt   <= '0;
            len_q      <= len_words;
            last_taken <= 1'b0;
            run_cycles <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
         end else if (start_bad) begin
            err <= 1'b1;
         end
         if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (word_end) begin
               imem_we    <= 1'b1;
               imem_wdata <= {s_data, word_buf};
               imem_addr  <= word_cnt[ADDR_W-1:0];
               word_cnt   <= word_cnt + (ADDR_W+1)'(1);
               if (last_word) last_taken <= 1'b1;
            end else begin
               word_buf[{byte_cnt, 3'b000} +: 8] <= s_data;
            end
         end
         if (state == RUN) begin
            run_cycles <= run_cycles + 32'd1;
            if (halt_hit) begin
               done <= 1'b1;
               err  <= 1'b0;
            end else if (timeout_hit) begin
               done <= 1'b1;
               err  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// tb/tb_cpu_boot_sequencer.sv - self-checking bench for cpu_boot_sequencer
module tb_cpu_boot_sequencer;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W:0]   len_words;
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic [31:0]       cpu_instr;
   logic [31:0]       run_cycles;
   logic              busy;
   logic              done;
   logic              err;

   cpu_boot_sequencer #(
      .ADDR_W    (ADDR_W),
      .IMEM_DEPTH(256),
      .HALT_INSTR(32'h00000073),
      .MAX_CYCLES(16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .len_words (len_words),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_reset (cpu_reset),
      .cpu_instr (cpu_instr),
      .run_cycles(run_cycles),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   typedef struct {
      logic [ADDR_W:0] len;
      logic            exp_err;
      logic            exp_busy;
      logic            exp_sready;
   } start_vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   int         checks = 0;
   int         errors = 0;
   int         we_count = 0;
   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] tx_bytes[$];
   start_vec_t svec[3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // scoreboard: every write pulse must match the next expected {addr, data}
   always @(negedge clk) begin
      if (reset && imem_we) begin
         we_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h@%h required=none", imem_wdata, imem_addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
            chk("wr_data", imem_wdata, mon_e.data);
            chk("wr_cpu_reset", 32'(cpu_reset), 32'd1);
         end
      end
   end

   task automatic do_start(input logic [ADDR_W:0] len);
      @(negedge clk);
      start = 1'b1;
      len_words = len;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(negedge clk);
         s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data = b;
      for (int k = 0; k < 50 && !s_ready; k++) @(negedge clk);
      chk("byte_ready_bound", 32'(s_ready), 32'd1);
   endtask

   // on return with final_checks set, the current negedge is the first RUN cycle
   task automatic load(input logic [ADDR_W:0] len, input bit gaps, input bit final_checks);
      do_start(len);
      chk("load_busy", 32'(busy), 32'd1);
      chk("load_err_clr", 32'(err), 32'd0);
      chk("load_runc_clr", run_cycles, 32'd0);
      chk("load_sready", 32'(s_ready), 32'd1);
      for (int i = 0; i < tx_bytes.size(); i++)
         send_byte(tx_bytes[i], (gaps && i != 0) ? int'($urandom_range(1, 3)) : 0);
      @(negedge clk);
      s_valid = 1'b0;
      if (final_checks) begin
         chk("last_we", 32'(imem_we), 32'd1);
         chk("last_sready_low", 32'(s_ready), 32'd0);
         chk("last_cpu_reset", 32'(cpu_reset), 32'd1);
         @(negedge clk);
         chk("release_cpu_reset", 32'(cpu_reset), 32'd0);
         chk("release_we_low", 32'(imem_we), 32'd0);
         chk("release_busy", 32'(busy), 32'd1);
      end
   endtask

   initial begin
      bit hold_ok;

      svec[0] = '{len: 9'd0,   exp_err: 1'b1, exp_busy: 1'b0, exp_sready: 1'b0};
      svec[1] = '{len: 9'd300, exp_err: 1'b1, exp_busy: 1'b0, exp_sready: 1'b0};
      svec[2] = '{len: 9'd257, exp_err: 1'b1, exp_busy: 1'b0, exp_sready: 1'b0};

      reset = 1'b1;
      start = 1'b0;
      len_words = '0;
      s_valid = 1'b0;
      s_data = '0;
      cpu_instr = '0;

      // reset asserted between edges must take effect without a clock
      #3 reset = 1'b0;
      #1;
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_sready", 32'(s_ready), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_runc", run_cycles, 32'd0);
      chk("rst_done_err_busy", {29'd0, done, err, busy}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 3; i++) begin
         do_start(svec[i].len);
         chk($sformatf("badlen%0d_err", i), 32'(err), 32'(svec[i].exp_err));
         chk($sformatf("badlen%0d_busy", i), 32'(busy), 32'(svec[i].exp_busy));
         chk($sformatf("badlen%0d_sready", i), 32'(s_ready), 32'(svec[i].exp_sready));
      end

      // two words back-to-back, then halt on the third fetched instruction
      tx_bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};
      exp_q.push_back('{addr: 8'd0, data: 32'h00500513});
      exp_q.push_back('{addr: 8'd1, data: 32'h00a00593});
      load(9'd2, 1'b0, 1'b1);
      cpu_instr = 32'h00500513;
      @(negedge clk);
      cpu_instr = 32'h00a00593;
      @(negedge clk);
      cpu_instr = 32'h00000073;
      @(negedge clk);
      chk("halt_runc", run_cycles, 32'd3);
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_err", 32'(err), 32'd0);
      chk("halt_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      hold_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (run_cycles !== 32'd3 || done !== 1'b1 || err !== 1'b0 || cpu_reset !== 1'b1)
            hold_ok = 1'b0;
      end
      chk("halt_hold", 32'(hold_ok), 32'd1);
      cpu_instr = 32'h0;

      do_start(9'd0);
      chk("halted_badlen_err", 32'(err), 32'd1);
      chk("halted_badlen_done", 32'(done), 32'd1);
      chk("halted_badlen_runc", run_cycles, 32'd3);

      // same program with stream gaps, then run to the cycle budget
      exp_q.push_back('{addr: 8'd0, data: 32'h00500513});
      exp_q.push_back('{addr: 8'd1, data: 32'h00a00593});
      load(9'd2, 1'b1, 1'b1);
      for (int k = 0; k < 40 && !done; k++) @(negedge clk);
      chk("tmo_done", 32'(done), 32'd1);
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_runc", run_cycles, 32'd16);
      chk("tmo_cpu_reset", 32'(cpu_reset), 32'd1);

      // reset after six bytes discards the partial second word
      tx_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'haa, 8'hbb};
      exp_q.push_back('{addr: 8'd0, data: 32'h12345678});
      load(9'd2, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("midrst_sready", 32'(s_ready), 32'd0);
      chk("midrst_busy_done_err", {29'd0, done, err, busy}, 32'd0);
      chk("midrst_runc", run_cycles, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      tx_bytes = '{8'hef, 8'hbe, 8'had, 8'hde};
      exp_q.push_back('{addr: 8'd0, data: 32'hdeadbeef});
      load(9'd1, 1'b0, 1'b1);
      repeat (3) @(negedge clk);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      chk("we_pulses", 32'(we_count), 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_boot_sequencer.md
Name: cpu_boot_sequencer

Overview:
Sequences bring-up of the single-cycle RV32 core (top_cpu).
- Holds the core in reset and loads a program into instruction memory from a byte stream.
- Releases the core, then counts execution cycles until the core fetches a halt instruction or a cycle budget expires.
- Sits between the bench/host interface and top_cpu's reset and instruction-memory write port.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory (at most 2^ADDR_W).
- HALT_INSTR, 32'h00000073, instruction encoding (ecall) that terminates a run.
- MAX_CYCLES, 1024, run-cycle budget before a timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- len_words  in  ADDR_W+1  number of words to load, sampled on start.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  byte-stream ready.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  instruction-memory word address.
- imem_wdata  out  32  instruction-memory write data.
- cpu_reset  out  1  active-high reset to top_cpu.
- cpu_instr  in  32  instruction currently fetched by top_cpu.
- run_cycles  out  32  clock edges spent in RUN.
- busy  out  1  high in LOAD or RUN.
- done  out  1  run finished (halt or timeout).
- err  out  1  bad length or timeout.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, cpu_reset=1, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, run_cycles=0, busy=0, done=0, err=0, byte and word counters=0.
- Reset asserted mid-operation: all outputs take their reset values immediately and any partial word is discarded. The next load starts at address 0.
- States: IDLE, LOAD, RUN, HALTED. busy = (LOAD|RUN). cpu_reset=0 only in RUN.
- IDLE/HALTED, start=1:
  - If 1 <= len_words <= IMEM_DEPTH: go to LOAD; clear done, err, run_cycles, byte and word counters.
  - Otherwise: set err=1, done unchanged, stay in the current state.
- start is ignored in LOAD and RUN.
- LOAD, byte handling:
  - s_ready=1 on every cycle in LOAD until the last byte of the last word is accepted; it is low from the following cycle.
  - A byte transfers when s_valid & s_ready.
  - Little-endian assembly: the 1st byte goes to [7:0], the 4th byte to [31:24].
  - Gaps in s_valid are allowed; the byte counter holds across gaps.
- LOAD, word write:
  - On the edge accepting the 4th byte of a word, register imem_wdata = assembled word and imem_addr = word index, and assert imem_we.
  - imem_we is high for exactly one cycle per word. Back-to-back streaming (a byte every cycle) is sustained with no stall.
  - The word index increments after each write.
- LOAD exit: on the edge ending the write cycle of word len_words-1, go to RUN. cpu_reset falls in the cycle after the final imem_we pulse. imem_we is never high while cpu_reset=0.
- RUN:
  - run_cycles increments on every rising edge in RUN, including the terminating edge.
  - cpu_instr is compared with HALT_INSTR on each edge in RUN only.
  - On a match: go to HALTED with done=1, err=0.
  - Otherwise, if run_cycles == MAX_CYCLES-1 on that edge: go to HALTED with done=1, err=1 (run_cycles ends at MAX_CYCLES).
  - Halt takes priority over timeout when both occur on the same edge.
- HALTED: cpu_reset=1; run_cycles, done and err hold. start re-enters LOAD and overwrites memory from address 0.
- run_cycles is 32-bit. It cannot wrap because MAX_CYCLES < 2^32 is required.

Test Plan:
1. Reset: assert reset low mid-clock -> cpu_reset=1, s_ready=0, imem_we=0, run_cycles=0, done=0, err=0, all immediately without waiting for a clock edge.
2. Load 2 words: start with len_words=2, bytes 13 05 50 00 93 05 a0 00 sent back-to-back -> imem_we pulses exactly twice: addr 0 = 0x00500513, addr 1 = 0x00a00593. cpu_reset falls 1 cycle after the second pulse.
3. Stream gaps: same bytes with s_valid low for 1–3 random cycles between bytes -> identical writes and addresses, no extra imem_we pulses.
4. Halt detection: after release, drive cpu_instr = 0x00500513, 0x00a00593, 0x00000073 on successive cycles -> HALTED with run_cycles=3, done=1, err=0, cpu_reset=1; values hold for 20 further cycles.
5. Timeout: MAX_CYCLES=16, cpu_instr never equals HALT_INSTR -> done=1, err=1, run_cycles=16, cpu_reset=1.
6. Bad length and reset during load:
   - start with len_words=0 -> err=1, state stays IDLE, s_ready=0.
   - A second start with len_words=300 (> IMEM_DEPTH) behaves the same way.
   - Pull reset low after 6 bytes of a load, then reload 1 word -> single write at addr 0 with the new data.
